// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding mux selects and load-use stall for the 5-stage pipeline.
// Optional perf counters (stall_cnt, fwd_cnt) are enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  fwd_a_mem,
    output logic                  fwd_a_wb,
    output logic                  fwd_b_mem,
    output logic                  fwd_b_wb,
    output logic                  stall
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
`endif
);

    logic                  ex_valid_q, ex_we_q, ex_load_q;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic                  mem_valid_q, mem_we_q, mem_load_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  wb_valid_q, wb_we_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;

    logic ex_valid_d, mem_valid_d;
    logic ex_writes, mem_writes, wb_writes;
    logic mem_hit_a, mem_hit_b;

    assign ex_writes  = ex_valid_q  & ex_we_q  & (ex_rd_q  != '0);
    assign mem_writes = mem_valid_q & mem_we_q & (mem_rd_q != '0);
    assign wb_writes  = wb_valid_q  & wb_we_q  & (wb_rd_q  != '0);

    assign stall = ~flush & id_valid & ex_load_q & ex_writes &
                   ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

    // Forward selects depend on flops only, so they never glitch with ID inputs.
    assign mem_hit_a = ex_valid_q & mem_writes & (mem_rd_q == ex_rs1_q);
    assign mem_hit_b = ex_valid_q & mem_writes & (mem_rd_q == ex_rs2_q);

    assign fwd_a_mem = mem_hit_a & ~mem_load_q;
    assign fwd_b_mem = mem_hit_b & ~mem_load_q;
    assign fwd_a_wb  = ex_valid_q & wb_writes & (wb_rd_q == ex_rs1_q);
    assign fwd_b_wb  = ex_valid_q & wb_writes & (wb_rd_q == ex_rs2_q);

    assign ex_valid_d  = id_valid & ~stall & ~flush;
    assign mem_valid_d = ex_valid_q & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rs1_q    <= id_rs1;
            ex_rs2_q    <= id_rs2;
            ex_rd_q     <= id_rd;
            ex_we_q     <= id_we;
            ex_load_q   <= id_is_load;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= ex_rd_q;
            mem_we_q    <= ex_we_q;
            mem_load_q  <= ex_load_q;
            wb_valid_q  <= mem_valid_q;
            wb_rd_q     <= mem_rd_q;
            wb_we_q     <= mem_we_q;
        end
    end

    // The load-use stall makes a load in MEM feeding EX unreachable.
    a_no_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_load_q & (mem_hit_a | mem_hit_b)));

`ifdef FWD_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [2:0]       fwd_inc;
    logic [CNT_W:0]   fwd_sum;

    assign fwd_inc = {2'b00, fwd_a_mem} + {2'b00, fwd_a_wb} +
                     {2'b00, fwd_b_mem} + {2'b00, fwd_b_wb};
    assign fwd_sum = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_inc);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        fwd_cnt_d = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
